// File: rtl/pipe_mux.sv
// pipe_mux: registered NUM-to-1 word multiplexer with a valid/ready handshake
// on both sides. One output register; a selected word appears one cycle after
// it is accepted. A sel that names no channel produces an all-zero word with
// out_err set.
//
// Optional build macro PIPE_MUX_SKID_EN adds a one-entry skid buffer so that
// in_ready comes from a register yet full throughput is kept. Without it,
// in_ready is combinational from out_ready.
//
// Ports:
//   clk       clock, rising edge
//   rst       synchronous active-high reset
//   in_data   NUM*WIDTH bits, channel k at [k*WIDTH +: WIDTH]
//   sel       channel select, sampled on accept
//   in_valid  upstream offers in_data/sel
//   in_ready  block can accept this cycle
//   flush     synchronous discard of all held words
//   out_data  registered selected word
//   out_err   word was produced by an out-of-range sel
//   out_valid out_data/out_err hold a word
//   out_ready downstream consumes the word this cycle
module pipe_mux #(
  parameter int WIDTH = 32,
  parameter int NUM   = 4,
  parameter int SEL_W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]     sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 flush,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_err,
  output logic                 out_valid,
  input  logic                 out_ready
);

`ifdef PIPE_MUX_SKID_EN
  typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, SKID = 2'd2} state_t;
`else
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;
`endif

  state_t state, state_nxt;

  logic [WIDTH-1:0] sel_word;
  logic             sel_err;
  logic [31:0]      sel_ext;
  logic [WIDTH-1:0] data_q;
  logic             err_q;
  logic             accept;
  logic             xfer;
  logic             load_in;

`ifdef PIPE_MUX_SKID_EN
  logic [WIDTH-1:0] skid_data;
  logic             skid_err;
  logic             load_skid;
  logic             load_from_skid;
  logic             ready_q;
`endif

  // Channel selection; any sel value without a matching channel yields zero
  // with the error flag.
  assign sel_ext = 32'(sel);

  always_comb begin
    sel_word = '0;
    sel_err  = 1'b1;
    for (int unsigned k = 0; k < NUM; k++) begin
      if (sel_ext == k) begin
        sel_word = in_data[k*WIDTH +: WIDTH];
        sel_err  = 1'b0;
      end
    end
  end

  assign out_valid = (state != EMPTY);
  assign out_data  = data_q;
  assign out_err   = err_q;

`ifdef PIPE_MUX_SKID_EN
  // ready_q already reflects "skid slot free"; rst/flush only gate it off.
  assign in_ready = ready_q && !rst && !flush;
`else
  assign in_ready = !rst && !flush && (!out_valid || out_ready);
`endif

  assign accept = in_valid && in_ready;
  assign xfer   = out_valid && out_ready;

  always_comb begin
    state_nxt = state;
    load_in   = 1'b0;
`ifdef PIPE_MUX_SKID_EN
    load_skid      = 1'b0;
    load_from_skid = 1'b0;
`endif
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_nxt = FULL;
            load_in   = 1'b1;
          end
        end
        FULL: begin
          if (xfer) begin
            if (accept) load_in = 1'b1;
            else        state_nxt = EMPTY;
          end
`ifdef PIPE_MUX_SKID_EN
          else if (accept) begin
            state_nxt = SKID;
            load_skid = 1'b1;
          end
`endif
        end
`ifdef PIPE_MUX_SKID_EN
        SKID: begin
          // in_ready is low here, so only the skid word can move forward.
          if (xfer) begin
            state_nxt      = FULL;
            load_from_skid = 1'b1;
          end
        end
`endif
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      err_q  <= 1'b0;
    end else if (load_in) begin
      data_q <= sel_word;
      err_q  <= sel_err;
    end
`ifdef PIPE_MUX_SKID_EN
    else if (load_from_skid) begin
      data_q <= skid_data;
      err_q  <= skid_err;
    end
`endif
  end

`ifdef PIPE_MUX_SKID_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_data <= '0;
      skid_err  <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      if (load_skid) begin
        skid_data <= sel_word;
        skid_err  <= sel_err;
      end
      ready_q <= (state_nxt != SKID);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_mux.sv
// Bench for pipe_mux: one NUM=4 instance and one NUM=3 instance share the
// same stimulus. Expected words are computed by a small model at accept time
// and queued; they are compared when each instance transfers a word out.
module tb_pipe_mux;

  logic         clk = 1'b0;
  logic         rst, flush, in_valid, out_ready;
  logic [1:0]   sel;
  logic [127:0] in_data;

  logic         in_ready_a, out_valid_a, out_err_a;
  logic [31:0]  out_data_a;
  logic         in_ready_b, out_valid_b, out_err_b;
  logic [31:0]  out_data_b;

  int total = 0;
  int bad   = 0;

  logic [32:0] q_a[$];
  logic [32:0] q_b[$];

`ifdef PIPE_MUX_SKID_EN
  localparam int MAXF = 2;
`else
  localparam int MAXF = 1;
`endif

  always #5 clk = ~clk;

  pipe_mux #(.WIDTH(32), .NUM(4), .SEL_W(2)) dut_a (
    .clk(clk), .rst(rst), .in_data(in_data), .sel(sel),
    .in_valid(in_valid), .in_ready(in_ready_a), .flush(flush),
    .out_data(out_data_a), .out_err(out_err_a),
    .out_valid(out_valid_a), .out_ready(out_ready)
  );

  pipe_mux #(.WIDTH(32), .NUM(3), .SEL_W(2)) dut_b (
    .clk(clk), .rst(rst), .in_data(in_data[95:0]), .sel(sel),
    .in_valid(in_valid), .in_ready(in_ready_b), .flush(flush),
    .out_data(out_data_b), .out_err(out_err_b),
    .out_valid(out_valid_b), .out_ready(out_ready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [32:0] model(input int n, input logic [127:0] d, input logic [1:0] s);
    if (int'(s) < n) return {1'b0, d[int'(s)*32 +: 32]};
    return {1'b1, 32'h0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard / hold monitors, sampled mid-cycle.
  logic        stall_a = 1'b0, stall_b = 1'b0;
  logic [32:0] held_a, held_b;

  always @(negedge clk) begin
    if (rst || flush) begin
      q_a.delete();
      stall_a = 1'b0;
    end else begin
      if (stall_a) begin
        check("hold_valid_a", 64'(out_valid_a), 64'd1);
        check("hold_word_a", 64'({out_err_a, out_data_a}), 64'(held_a));
      end
      if (out_valid_a && out_ready) begin
        check("q_nonempty_a", 64'(q_a.size() != 0), 64'd1);
        if (q_a.size() != 0) check("order_a", 64'({out_err_a, out_data_a}), 64'(q_a.pop_front()));
      end
      if (in_valid && in_ready_a) q_a.push_back(model(4, in_data, sel));
      stall_a = out_valid_a && !out_ready;
      held_a  = {out_err_a, out_data_a};
    end
  end

  always @(negedge clk) begin
    if (rst || flush) begin
      q_b.delete();
      stall_b = 1'b0;
    end else begin
      if (stall_b) begin
        check("hold_valid_b", 64'(out_valid_b), 64'd1);
        check("hold_word_b", 64'({out_err_b, out_data_b}), 64'(held_b));
      end
      if (out_valid_b && out_ready) begin
        check("q_nonempty_b", 64'(q_b.size() != 0), 64'd1);
        if (q_b.size() != 0) check("order_b", 64'({out_err_b, out_data_b}), 64'(q_b.pop_front()));
      end
      if (in_valid && in_ready_b) q_b.push_back(model(3, in_data, sel));
      stall_b = out_valid_b && !out_ready;
      held_b  = {out_err_b, out_data_b};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp41 [4];
    int acc;
    exp41[0] = 32'h11111111; exp41[1] = 32'h22222222;
    exp41[2] = 32'h33333333; exp41[3] = 32'h44444444;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    sel = 2'd0; in_data = 128'h44444444_33333333_22222222_11111111;
    tick(); tick();
    check("rst_valid", 64'(out_valid_a), 64'd0);
    check("rst_data", 64'(out_data_a), 64'd0);
    check("rst_err_b", 64'(out_err_b), 64'd0);
    check("rst_ready", 64'(in_ready_a), 64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 64'(in_ready_a), 64'd1);

    // Single accept, sel=2.
    sel = 2'd2; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("single_valid", 64'(out_valid_a), 64'd1);
    check("single_data", 64'(out_data_a), 64'h33333333);
    check("single_err", 64'(out_err_a), 64'd0);
    out_ready = 1'b1;
    tick();
    check("single_drained", 64'(out_valid_a), 64'd0);

    // Out-of-range select on the NUM=3 instance.
    sel = 2'd3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("oor_data_b", 64'(out_data_b), 64'd0);
    check("oor_err_b", 64'(out_err_b), 64'd1);
    check("inrange_data_a", 64'(out_data_a), 64'h44444444);
    check("inrange_err_a", 64'(out_err_a), 64'd0);
    tick();

    // Streaming with out_ready held high: no bubbles.
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i); in_valid = 1'b1;
      tick();
      check("stream_valid", 64'(out_valid_a), 64'd1);
      check("stream_data", 64'(out_data_a), 64'(exp41[i]));
    end
    in_valid = 1'b0;
    tick();
    check("stream_end", 64'(out_valid_a), 64'd0);

    // Stall for 3 cycles with in_valid high.
    out_ready = 1'b0; acc = 0;
    for (int i = 0; i < 3; i++) begin
      sel = 2'(i + 1); in_valid = 1'b1;
      #1;
      if (in_ready_a) acc++;
      tick();
    end
    #1;
    check("stall_accepts", 64'(acc), 64'(MAXF));
    check("stall_ready", 64'(in_ready_a), 64'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("stall_drained", 64'(out_valid_a), 64'd0);
    check("stall_q_a", 64'(q_a.size()), 64'd0);

    // Flush from FULL (and SKID when present).
    for (int f = 1; f <= MAXF; f++) begin
      out_ready = 1'b0; in_valid = 1'b1; sel = 2'd0;
      for (int i = 0; i < f; i++) tick();
      flush = 1'b1;
      #1;
      check("flush_ready", 64'(in_ready_a), 64'd0);
      tick();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      check("flush_valid", 64'(out_valid_a), 64'd0);
      for (int i = 0; i < 3; i++) begin
        tick();
        check("flush_no_stale", 64'(out_valid_a), 64'd0);
      end
    end

    // Reset mid-stream with out_ready low.
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd3;
    for (int i = 0; i < MAXF; i++) tick();
    rst = 1'b1;
    #1;
    check("mid_rst_ready0", 64'(in_ready_a), 64'd0);
    tick();
    check("mid_rst_valid", 64'(out_valid_a), 64'd0);
    check("mid_rst_data", 64'(out_data_a), 64'd0);
    check("mid_rst_err_b", 64'(out_err_b), 64'd0);
    check("mid_rst_ready1", 64'(in_ready_a), 64'd0);
    tick();
    check("mid_rst_ready2", 64'(in_ready_b), 64'd0);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("mid_rst_release", 64'(in_ready_a), 64'd1);
    tick();

    // Random traffic against the scoreboard.
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      sel       = 2'($urandom_range(0, 3));
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      tick();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (!out_valid_a && !out_valid_b) break;
      tick();
    end
    check("drain_idle_a", 64'(out_valid_a), 64'd0);
    check("drain_idle_b", 64'(out_valid_b), 64'd0);
    check("drain_q_a", 64'(q_a.size()), 64'd0);
    check("drain_q_b", 64'(q_b.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_mux.md
PIPE_MUX -- requirements
Module: pipe_mux

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, which sets the bits per data word.
REQ-002 The block SHALL have parameter NUM, default 4, which sets the number of input channels (NUM >= 2).
REQ-003 The block SHALL have parameter SEL_W, default 2, which sets the select width (SEL_W >= clog2(NUM)).
REQ-004 Port clk SHALL be an input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst SHALL be an input, 1 bit: reset, synchronous and active-high.
REQ-006 Port in_data SHALL be an input, NUM*WIDTH bits; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 Port sel SHALL be an input, SEL_W bits: the channel select, sampled on accept.
REQ-008 Port in_valid SHALL be an input, 1 bit: the upstream offers in_data/sel.
REQ-009 Port in_ready SHALL be an output, 1 bit: the block can accept this cycle.
REQ-010 Port flush SHALL be an input, 1 bit: synchronous discard of all held words.
REQ-011 Port out_data SHALL be an output, WIDTH bits: the registered selected word.
REQ-012 Port out_err SHALL be an output, 1 bit: the word in out_data was produced by an out-of-range sel.
REQ-013 Port out_valid SHALL be an output, 1 bit: out_data/out_err hold a word.
REQ-014 Port out_ready SHALL be an input, 1 bit: downstream consumes the word this cycle.

Function
REQ-015 An accept SHALL occur when in_valid && in_ready are both high at a rising clk edge.
REQ-016 The selected word SHALL be channel sel when sel < NUM; otherwise it SHALL be all-zero with err=1.
REQ-017 Latency from accept to out_valid SHALL be exactly 1 cycle, with no combinational path from in_data or sel to out_data.
REQ-018 A transfer-out SHALL occur when out_valid && out_ready are both high.
REQ-019 While out_valid && !out_ready, out_data and out_err SHALL remain stable.
REQ-020 State EMPTY (out_valid=0): on accept, go to FULL.
REQ-021 State FULL with transfer-out and accept: stay FULL and load the new word.
REQ-022 State FULL with transfer-out and no accept: go to EMPTY.
REQ-023 State FULL with no transfer-out: hold; an accept in this state is defined in Configuration.
REQ-024 in_ready SHALL be driven by a register or by out_ready only, never by in_valid.
REQ-025 When flush=1: in_ready SHALL be 0 that cycle; the next state SHALL be EMPTY with all held words discarded; no transfer-out is counted.
REQ-026 When flush and out_ready are high in the same cycle, the word on out_data MAY be observed by downstream but SHALL NOT be re-presented.
REQ-027 Word order SHALL be preserved; no word SHALL be duplicated or dropped, except under flush or reset.

Reset
REQ-028 When rst=1 at a clk edge: state SHALL become EMPTY, out_valid=0, out_data=0, out_err=0, and any skid entry SHALL be cleared.
REQ-029 While rst=1, in_ready SHALL be 0.
REQ-030 rst SHALL take priority over flush and accept, including when asserted mid-transfer.

Configuration
REQ-031 Macro PIPE_MUX_SKID_EN SHALL control the skid buffer.
REQ-032 With PIPE_MUX_SKID_EN defined: a one-entry skid buffer SHALL be added, adding state SKID.
REQ-033 With the macro defined: in_ready = !skid_valid, registered.
REQ-034 With the macro defined: an accept in FULL without transfer-out SHALL go to SKID.
REQ-035 With the macro defined, in SKID: a transfer-out SHALL move the skid word to the output and return to FULL.
REQ-036 With the macro defined, the block SHALL sustain 1 word per cycle with a registered in_ready.
REQ-037 Without PIPE_MUX_SKID_EN: in_ready = !out_valid || out_ready, combinational from out_ready.
REQ-038 Without the macro: there SHALL be no SKID state.

Verification
REQ-039 The bench SHALL cover: NUM=4, in_data = {0x44444444, 0x33333333, 0x22222222, 0x11111111}, sel=2, single accept -> next cycle out_valid=1, out_data=0x33333333, out_err=0.
REQ-040 The bench SHALL cover: NUM=3, sel=3 accepted -> out_data=0x00000000, out_err=1.
REQ-041 The bench SHALL cover: out_ready held 1, sel stepping 0,1,2,3 on consecutive cycles -> outputs 0x11111111, 0x22222222, 0x33333333, 0x44444444 on consecutive cycles, no bubbles.
REQ-042 The bench SHALL cover, with the skid macro defined: out_ready=0 for 3 cycles while in_valid=1 -> exactly 2 accepts, then in_ready=0; on release the 2 words emerge in order.
REQ-043 The bench SHALL cover: flush while FULL (and SKID when enabled) -> next cycle out_valid=0, no stale word emerges later.
REQ-044 The bench SHALL cover: rst asserted mid-stream with out_ready=0 -> next cycle out_valid=0, out_data=0, out_err=0, in_ready=0 until rst falls.
